// File: rtl/video_timing_pkg.sv
// Shared raster-timing types and constants for the TMDS video path.
// Defaults describe 1280x720 @ 60 Hz on a 74.25 MHz pixel clock.
package video_timing_pkg;

    typedef enum logic [1:0] {H_ACTIVE, H_FP, H_SYNC, H_BP} h_phase_t;

    localparam int DEF_ACTIVE_H_PIXELS = 1280;
    localparam int DEF_H_FRONT_PORCH   = 110;
    localparam int DEF_H_SYNC_WIDTH    = 40;
    localparam int DEF_H_BACK_PORCH    = 220;
    localparam int DEF_ACTIVE_LINES    = 720;
    localparam int DEF_V_FRONT_PORCH   = 5;
    localparam int DEF_V_SYNC_WIDTH    = 5;
    localparam int DEF_V_BACK_PORCH    = 20;
    localparam int DEF_FPS             = 60;

    // TMDS control symbols, indexed by {c1, c0}; blue carries {vsync, hsync}.
    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX up counter; wrap_out flags the enabled cycle that returns it to 0.
// One-cycle update latency, no backpressure (advances whenever en_in is high).
module wrap_counter #(
    parameter int MAX   = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_in,
    output logic [WIDTH-1:0] count_out,
    output logic             wrap_out
);

    localparam logic [WIDTH-1:0] C_LAST = WIDTH'(MAX - 1);

    logic [WIDTH-1:0] r_count;

    assign wrap_out  = en_in && (r_count == C_LAST);
    assign count_out = r_count;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_count <= '0;
        end else if (en_in) begin
            r_count <= wrap_out ? '0 : r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/video_sig_gen.sv
// Raster timing generator: position, active-draw, syncs, new-frame strobe, frame count.
// All outputs registered and decoded from the next position so they align with hcount/vcount.
module video_sig_gen
    import video_timing_pkg::*;
#(
    parameter int ACTIVE_H_PIXELS = DEF_ACTIVE_H_PIXELS,
    parameter int H_FRONT_PORCH   = DEF_H_FRONT_PORCH,
    parameter int H_SYNC_WIDTH    = DEF_H_SYNC_WIDTH,
    parameter int H_BACK_PORCH    = DEF_H_BACK_PORCH,
    parameter int ACTIVE_LINES    = DEF_ACTIVE_LINES,
    parameter int V_FRONT_PORCH   = DEF_V_FRONT_PORCH,
    parameter int V_SYNC_WIDTH    = DEF_V_SYNC_WIDTH,
    parameter int V_BACK_PORCH    = DEF_V_BACK_PORCH,
    parameter int FPS             = DEF_FPS
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        ad_out,
    output logic        nf_out,
    output logic [5:0]  fc_out
);

    localparam int H_SYNC_START = ACTIVE_H_PIXELS + H_FRONT_PORCH;
    localparam int H_BP_START   = H_SYNC_START + H_SYNC_WIDTH;
    localparam int TOTAL_H      = H_BP_START + H_BACK_PORCH;
    localparam int V_SYNC_START = ACTIVE_LINES + V_FRONT_PORCH;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_WIDTH;
    localparam int TOTAL_V      = V_SYNC_END + V_BACK_PORCH;

    if (TOTAL_H > 2048 || TOTAL_V > 1024 || FPS < 1 || FPS > 64) begin : g_bad_params
        $error("video_sig_gen: timing totals do not fit the output counter widths");
    end

    localparam logic [10:0] C_H_FP   = 11'(ACTIVE_H_PIXELS);
    localparam logic [10:0] C_H_SYNC = 11'(H_SYNC_START);
    localparam logic [10:0] C_H_BP   = 11'(H_BP_START);
    localparam logic [9:0]  C_V_ACT  = 10'(ACTIVE_LINES);
    localparam logic [9:0]  C_VS_BEG = 10'(V_SYNC_START);
    localparam logic [9:0]  C_VS_END = 10'(V_SYNC_END);

    logic       r_running;
    h_phase_t   r_phase;
    h_phase_t   w_phase_next;
    logic       r_hs, r_vs, r_ad, r_nf;
    logic       w_hs_next;
    logic       w_h_wrap, w_v_wrap, w_fc_wrap_unused;
    logic [10:0] w_h_next;
    logic [9:0]  w_v_next;
    logic        w_nf_next;

    wrap_counter #(.MAX(TOTAL_H), .WIDTH(11)) u_hcount (
        .clk_in(clk_in), .rst_in(rst_in), .en_in(r_running),
        .count_out(hcount_out), .wrap_out(w_h_wrap)
    );

    wrap_counter #(.MAX(TOTAL_V), .WIDTH(10)) u_vcount (
        .clk_in(clk_in), .rst_in(rst_in), .en_in(w_h_wrap),
        .count_out(vcount_out), .wrap_out(w_v_wrap)
    );

    wrap_counter #(.MAX(FPS), .WIDTH(6)) u_fcount (
        .clk_in(clk_in), .rst_in(rst_in), .en_in(w_nf_next),
        .count_out(fc_out), .wrap_out(w_fc_wrap_unused)
    );

    // Position the counters will hold after this edge; stays (0,0) on the first cycle out of reset.
    assign w_h_next  = !r_running ? hcount_out : (w_h_wrap ? 11'd0 : hcount_out + 11'd1);
    assign w_v_next  = !w_h_wrap  ? vcount_out : (w_v_wrap ? 10'd0 : vcount_out + 10'd1);
    assign w_nf_next = r_running && (w_h_next == C_H_FP) && (w_v_next == C_V_ACT);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_phase <= H_ACTIVE;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    always_comb begin
        w_phase_next = r_phase;
        case (r_phase)
            H_ACTIVE: if (w_h_next == C_H_FP)   w_phase_next = H_FP;
            H_FP:     if (w_h_next == C_H_SYNC) w_phase_next = H_SYNC;
            H_SYNC:   if (w_h_next == C_H_BP)   w_phase_next = H_BP;
            H_BP:     if (w_h_next == 11'd0)    w_phase_next = H_ACTIVE;
            default:                            w_phase_next = H_ACTIVE;
        endcase
    end

    always_comb begin
        w_hs_next = (w_phase_next == H_SYNC);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_running <= 1'b0;
            r_hs      <= 1'b0;
            r_vs      <= 1'b0;
            r_ad      <= 1'b0;
            r_nf      <= 1'b0;
        end else begin
            r_running <= 1'b1;
            r_hs      <= w_hs_next;
            r_vs      <= (w_v_next >= C_VS_BEG) && (w_v_next < C_VS_END);
            r_ad      <= (w_h_next < C_H_FP) && (w_v_next < C_V_ACT);
            r_nf      <= w_nf_next;
        end
    end

    assign hs_out = r_hs;
    assign vs_out = r_vs;
    assign ad_out = r_ad;
    assign nf_out = r_nf;

endmodule

// File: tb/tb_video_sig_gen.sv
// Randomized-reset bench: a 720p instance and a tiny-raster instance checked each cycle
// against a pixel-walk reference model.
module tb_video_sig_gen;

    typedef struct {
        int ah, hfp, hsw, hbp, al, vfp, vsw, vbp, fps;
    } cfg_t;

    typedef struct {
        bit zero;
        bit running;
        int h, v, fc;
    } mst_t;

    logic clk_in = 1'b0;
    logic rst_b, rst_s;

    logic [10:0] h_b, h_s;
    logic [9:0]  v_b, v_s;
    logic        hs_b, vs_b, ad_b, nf_b;
    logic        hs_s, vs_s, ad_s, nf_s;
    logic [5:0]  fc_b, fc_s;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk_in = ~clk_in;

    video_sig_gen u_big (
        .clk_in(clk_in), .rst_in(rst_b),
        .hcount_out(h_b), .vcount_out(v_b),
        .hs_out(hs_b), .vs_out(vs_b), .ad_out(ad_b), .nf_out(nf_b), .fc_out(fc_b)
    );

    video_sig_gen #(
        .ACTIVE_H_PIXELS(4), .H_FRONT_PORCH(1), .H_SYNC_WIDTH(1), .H_BACK_PORCH(1),
        .ACTIVE_LINES(2),    .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1), .V_BACK_PORCH(1),
        .FPS(3)
    ) u_small (
        .clk_in(clk_in), .rst_in(rst_s),
        .hcount_out(h_s), .vcount_out(v_s),
        .hs_out(hs_s), .vs_out(vs_s), .ad_out(ad_s), .nf_out(nf_s), .fc_out(fc_s)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: walk the raster one pixel per clock, then derive every output from its position.
    function automatic mst_t mstep(input cfg_t c, input mst_t s, input bit rst);
        mst_t n;
        int th, tv;
        th = c.ah + c.hfp + c.hsw + c.hbp;
        tv = c.al + c.vfp + c.vsw + c.vbp;
        n = s;
        if (rst) begin
            n.zero = 1; n.running = 0; n.h = 0; n.v = 0; n.fc = 0;
        end else if (!s.running) begin
            n.zero = 0; n.running = 1; n.h = 0; n.v = 0;
        end else begin
            n.zero = 0;
            n.h = s.h + 1;
            if (n.h == th) begin
                n.h = 0;
                n.v = (s.v + 1 == tv) ? 0 : s.v + 1;
            end
            if (n.h == c.ah && n.v == c.al) n.fc = (s.fc + 1) % c.fps;
        end
        return n;
    endfunction

    task automatic cmp(input string p, input cfg_t c, input mst_t s,
                       input int h, input int v, input int hs, input int vs,
                       input int ad, input int nf, input int fc);
        bit live;
        int hs0, vs0;
        live = !s.zero;
        hs0  = c.ah + c.hfp;
        vs0  = c.al + c.vfp;
        check({p, ".hcount"}, h, s.h);
        check({p, ".vcount"}, v, s.v);
        check({p, ".fc"}, fc, s.fc);
        check({p, ".ad"}, ad, int'(live && s.h < c.ah && s.v < c.al));
        check({p, ".hs"}, hs, int'(live && s.h >= hs0 && s.h < hs0 + c.hsw));
        check({p, ".vs"}, vs, int'(live && s.v >= vs0 && s.v < vs0 + c.vsw));
        check({p, ".nf"}, nf, int'(live && s.running && s.h == c.ah && s.v == c.al));
    endtask

    initial begin
        cfg_t big_c, small_c;
        mst_t mb, ms;
        int   frame_s, last_nf;
        bit   gap_ok;

        big_c   = '{ah:1280, hfp:110, hsw:40, hbp:220, al:720, vfp:5, vsw:5, vbp:20, fps:60};
        small_c = '{ah:4, hfp:1, hsw:1, hbp:1, al:2, vfp:1, vsw:1, vbp:1, fps:3};
        mb = '{zero:1, running:0, h:0, v:0, fc:0};
        ms = mb;
        frame_s = (small_c.ah + small_c.hfp + small_c.hsw + small_c.hbp)
                * (small_c.al + small_c.vfp + small_c.vsw + small_c.vbp);
        last_nf = 0;
        gap_ok  = 0;

        rst_b = 1'b1;
        rst_s = 1'b1;
        repeat (3) @(posedge clk_in);

        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk_in);
            cmp("big",   big_c,   mb, int'(h_b), int'(v_b), int'(hs_b), int'(vs_b),
                int'(ad_b), int'(nf_b), int'(fc_b));
            cmp("small", small_c, ms, int'(h_s), int'(v_s), int'(hs_s), int'(vs_s),
                int'(ad_s), int'(nf_s), int'(fc_s));

            if (nf_s) begin
                if (gap_ok) check("small.nf_gap", cyc - last_nf, frame_s);
                last_nf = cyc;
                gap_ok  = 1;
            end

            // 720p instance: clean first lines, one mid-line reset, then sparse random resets.
            rst_b = (cyc < 1) || (cyc == 3900) ||
                    (cyc > 5000 && $urandom_range(0, 2999) == 0);
            rst_s = (cyc < 1) || ($urandom_range(0, 299) == 0);
            if (rst_s) gap_ok = 0;

            @(posedge clk_in);
            mb = mstep(big_c,   mb, rst_b);
            ms = mstep(small_c, ms, rst_s);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
